instr_sequencer: RTL and testbench

Multi-cycle control sequencer for the 16-bit RISC datapath. It steps each instruction through fetch, decode, execute, memory and write-back. It owns the 6-bit program counter and generates every enable the datapath needs: instruction-memory read, instruction-register load, data-memory read/write, and register-file write. It sits beside `control_unit`, which keeps producing addresses, operands and immediates, and replaces the free-running, enable-less sequencing of the single-stage top level.

---
 rtl/proc_pkg.sv | 53 +++++
 rtl/mem_wait_counter.sv | 34 +++
 rtl/instr_sequencer.sv | 165 ++++++++++++++++
 tb/tb_instr_sequencer.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/proc_pkg.sv
// Shared definitions for the multi-cycle RISC sequencer.
// Holds the sequencer state encoding, instruction class and control subcode
// codes, the program counter width and the registered enable bundle.
// Optional feature macro: SEQ_SINGLE_STEP_EN (adds the PAUSE state).
package proc_pkg;

    localparam int unsigned PC_W  = 6;
    localparam int unsigned IR_W  = 16;
    localparam int unsigned CNT_W = 3;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_FETCH     = 3'd1,
        ST_DECODE    = 3'd2,
        ST_EXECUTE   = 3'd3,
        ST_MEM       = 3'd4,
        ST_WRITEBACK = 3'd5,
`ifdef SEQ_SINGLE_STEP_EN
        ST_HALT      = 3'd6,
        ST_PAUSE     = 3'd7
`else
        ST_HALT      = 3'd6
`endif
    } state_t;

    // Instruction class, ir[15:14]
    typedef enum logic [1:0] {
        CLS_ALU   = 2'b00,
        CLS_LOAD  = 2'b01,
        CLS_STORE = 2'b10,
        CLS_CTRL  = 2'b11
    } cls_t;

    // Control subcode, ir[13:12]
    typedef enum logic [1:0] {
        CTL_JMP  = 2'b00,
        CTL_BR   = 2'b01,
        CTL_HALT = 2'b10,
        CTL_NOP  = 2'b11
    } ctl_t;

    // Datapath enables, all driven from flops
    typedef struct packed {
        logic im_read_en;
        logic ir_load;
        logic dm_read_en;
        logic dm_write_en;
        logic reg_write_en;
        logic wb_sel;
        logic halted;
    } seq_out_t;

endpackage

// File: rtl/mem_wait_counter.sv
// Loadable down-counter that times the MEM state.
// Ports:
//   clk   - clock, rising edge
//   reset - asynchronous active-high reset
//   start - loads MEM_WAIT; pulse on the edge that enters MEM
//   done  - high during the last MEM cycle
module mem_wait_counter
    import proc_pkg::*;
#(
    parameter int unsigned MEM_WAIT = 1
) (
    input  logic clk,
    input  logic reset,
    input  logic start,
    output logic done
);

    logic [CNT_W-1:0] count;

    // done is registered: it rises on the edge where count reaches zero
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
            done  <= 1'b0;
        end else if (start) begin
            count <= CNT_W'(MEM_WAIT);
            done  <= (MEM_WAIT == 0);
        end else if (count != '0) begin
            count <= count - CNT_W'(1);
            done  <= (count == CNT_W'(1));
        end
    end

endmodule

// File: rtl/instr_sequencer.sv
// Multi-cycle control sequencer: FETCH, DECODE, EXECUTE, MEM, WRITEBACK.
// Owns the program counter and every datapath enable.
// Ports:
//   clk, reset       - clock and asynchronous active-high reset
//   run              - start request, sampled only in IDLE
//   ir               - instruction register contents
//   bool_alu         - branch condition, sampled on the edge ending EXECUTE
//   step             - single-step advance (SEQ_SINGLE_STEP_EN only)
//   pc               - program counter / instruction-memory address
//   im_read_en, ir_load, dm_read_en, dm_write_en, reg_write_en - enables
//   wb_sel           - write-back source, 1 = data memory, 0 = ALU
//   halted           - high in HALT
// Optional feature macro: SEQ_SINGLE_STEP_EN (step port and PAUSE state).
module instr_sequencer #(
    parameter int unsigned MEM_WAIT = 1,
    parameter int unsigned PC_W     = proc_pkg::PC_W
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      run,
    input  logic [proc_pkg::IR_W-1:0] ir,
    input  logic                      bool_alu,
`ifdef SEQ_SINGLE_STEP_EN
    input  logic                      step,
`endif
    output logic [PC_W-1:0]           pc,
    output logic                      im_read_en,
    output logic                      ir_load,
    output logic                      dm_read_en,
    output logic                      dm_write_en,
    output logic                      reg_write_en,
    output logic                      wb_sel,
    output logic                      halted
);
    import proc_pkg::*;

    // Where a finished instruction goes next
`ifdef SEQ_SINGLE_STEP_EN
    localparam state_t ST_NEXT = ST_PAUSE;
`else
    localparam state_t ST_NEXT = ST_FETCH;
`endif

    state_t          state_q, state_d;
    cls_t            cls_q;
    logic [PC_W-1:0] pc_q, pc_d;
    logic [PC_W-1:0] pc_inc, pc_tgt;
    logic            cnt_start, cnt_done;
    seq_out_t        out_d, out_q;
    logic            unused_ir_bits;

    assign pc_inc         = pc_q + PC_W'(1);
    assign pc_tgt         = PC_W'(ir[5:0]);
    assign unused_ir_bits = ^ir[11:6];

    mem_wait_counter #(
        .MEM_WAIT (MEM_WAIT)
    ) u_wait (
        .clk   (clk),
        .reset (reset),
        .start (cnt_start),
        .done  (cnt_done)
    );

    // State register, latched class and program counter
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cls_q   <= CLS_ALU;
            pc_q    <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            if (state_q == ST_DECODE) begin
                cls_q <= cls_t'(ir[15:14]);
            end
        end
    end

    // Next state and next pc; pc only moves on leaving EXECUTE
    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        cnt_start = 1'b0;
        case (state_q)
            ST_IDLE:      if (run) state_d = ST_FETCH;
            ST_FETCH:     state_d = ST_DECODE;
            ST_DECODE:    state_d = ST_EXECUTE;
            ST_EXECUTE: begin
                case (cls_q)
                    CLS_ALU: begin
                        state_d = ST_WRITEBACK;
                        pc_d    = pc_inc;
                    end
                    CLS_LOAD, CLS_STORE: begin
                        state_d   = ST_MEM;
                        pc_d      = pc_inc;
                        cnt_start = 1'b1;
                    end
                    default: begin
                        state_d = ST_NEXT;
                        case (ctl_t'(ir[13:12]))
                            CTL_JMP:  pc_d = pc_tgt;
                            CTL_BR:   pc_d = bool_alu ? pc_tgt : pc_inc;
                            CTL_HALT: state_d = ST_HALT;
                            default:  pc_d = pc_inc;
                        endcase
                    end
                endcase
            end
            ST_MEM: begin
                if (cnt_done) begin
                    state_d = (cls_q == CLS_LOAD) ? ST_WRITEBACK : ST_NEXT;
                end
            end
            ST_WRITEBACK: state_d = ST_NEXT;
            ST_HALT:      state_d = ST_HALT;
`ifdef SEQ_SINGLE_STEP_EN
            ST_PAUSE:     if (step) state_d = ST_FETCH;
`endif
            default:      state_d = ST_IDLE;
        endcase
    end

    // Enables for the state being entered; cls_q is already stable whenever
    // a class-dependent state is entered, so the flops equal a Moore decode
    always_comb begin
        out_d = '0;
        case (state_d)
            ST_FETCH: begin
                out_d.im_read_en = 1'b1;
                out_d.ir_load    = 1'b1;
            end
            ST_MEM: begin
                out_d.dm_read_en  = (cls_q == CLS_LOAD);
                out_d.dm_write_en = (cls_q == CLS_STORE);
            end
            ST_WRITEBACK: begin
                out_d.reg_write_en = 1'b1;
                out_d.wb_sel       = (cls_q == CLS_LOAD);
            end
            ST_HALT:  out_d.halted = 1'b1;
            default:  out_d = '0;
        endcase
    end

    // Glitch-free enable flops, cleared asynchronously with the state
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_q <= '0;
        end else begin
            out_q <= out_d;
        end
    end

    assign pc           = pc_q;
    assign im_read_en   = out_q.im_read_en;
    assign ir_load      = out_q.ir_load;
    assign dm_read_en   = out_q.dm_read_en;
    assign dm_write_en  = out_q.dm_write_en;
    assign reg_write_en = out_q.reg_write_en;
    assign wb_sel       = out_q.wb_sel;
    assign halted       = out_q.halted;

endmodule

// File: tb/tb_instr_sequencer.sv
// Scoreboard bench for instr_sequencer: every instruction pushes its
// expected per-cycle {pc, enables} trace, which is popped and compared
// each falling edge. Build with SEQ_SINGLE_STEP_EN to exercise stepping.
module tb_instr_sequencer;

    localparam int unsigned MW = 2;
    localparam int unsigned PW = 6;
    localparam int unsigned VW = PW + 7;

    // Enable patterns {im, irl, dmr, dmw, rwe, wbs, hlt}
    localparam logic [6:0] E_NONE   = 7'b0000000;
    localparam logic [6:0] E_FETCH  = 7'b1100000;
    localparam logic [6:0] E_DMR    = 7'b0010000;
    localparam logic [6:0] E_DMW    = 7'b0001000;
    localparam logic [6:0] E_WB_ALU = 7'b0000100;
    localparam logic [6:0] E_WB_LD  = 7'b0000110;
    localparam logic [6:0] E_HALT   = 7'b0000001;

    logic          clk = 1'b0;
    logic          reset;
    logic          run;
    logic [15:0]   ir;
    logic          bool_alu;
    logic          step;
    logic [PW-1:0] pc;
    logic          im_read_en, ir_load, dm_read_en, dm_write_en;
    logic          reg_write_en, wb_sel, halted;

    int            n_tests = 0;
    int            n_fail  = 0;
    logic [VW-1:0] exp_q[$];
    logic [PW-1:0] exp_pc;
    bit            first_fetch;

    always #5 clk = ~clk;

    instr_sequencer #(
        .MEM_WAIT (MW),
        .PC_W     (PW)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .run          (run),
        .ir           (ir),
        .bool_alu     (bool_alu),
`ifdef SEQ_SINGLE_STEP_EN
        .step         (step),
`endif
        .pc           (pc),
        .im_read_en   (im_read_en),
        .ir_load      (ir_load),
        .dm_read_en   (dm_read_en),
        .dm_write_en  (dm_write_en),
        .reg_write_en (reg_write_en),
        .wb_sel       (wb_sel),
        .halted       (halted)
    );

    task automatic check(input string tag, input logic [VW-1:0] got, input logic [VW-1:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got pc=%0d en=%b, expected pc=%0d en=%b",
                     tag, got[VW-1:7], got[6:0], exp[VW-1:7], exp[6:0]);
        end
    endtask

    function automatic logic [VW-1:0] actual();
        return {pc, im_read_en, ir_load, dm_read_en, dm_write_en, reg_write_en, wb_sel, halted};
    endfunction

    function automatic logic [VW-1:0] mk(input logic [PW-1:0] p, input logic [6:0] e);
        return {p, e};
    endfunction

    // Expected cycle trace of one instruction, straight from the CPI table
    function automatic void push_instr(input logic [15:0] iv, input logic b);
        logic [PW-1:0] p;
        logic [PW-1:0] np;
        p  = exp_pc;
        np = p + PW'(1);
        exp_q.push_back(mk(p, E_FETCH));
        exp_q.push_back(mk(p, E_NONE));
        exp_q.push_back(mk(p, E_NONE));
        case (iv[15:14])
            2'b00: begin
                exp_q.push_back(mk(np, E_WB_ALU));
                exp_pc = np;
            end
            2'b01: begin
                for (int i = 0; i <= int'(MW); i++) exp_q.push_back(mk(np, E_DMR));
                exp_q.push_back(mk(np, E_WB_LD));
                exp_pc = np;
            end
            2'b10: begin
                for (int i = 0; i <= int'(MW); i++) exp_q.push_back(mk(np, E_DMW));
                exp_pc = np;
            end
            default: begin
                case (iv[13:12])
                    2'b00:   exp_pc = PW'(iv[5:0]);
                    2'b01:   exp_pc = b ? PW'(iv[5:0]) : np;
                    2'b10:   exp_pc = p;
                    default: exp_pc = np;
                endcase
            end
        endcase
    endfunction

    // Pop and compare n cycles; the instruction word appears after FETCH
    task automatic drain(input int n, input logic [15:0] iv, input logic b, input string tag);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            check(tag, actual(), exp_q.pop_front());
            if (i == 0) begin
                ir       = iv;
                bool_alu = b;
                step     = 1'b0;
            end else begin
                bool_alu = (i == 2) ? b : 1'($urandom_range(0, 1));
            end
        end
    endtask

    // In step mode, every instruction but the first after IDLE waits in PAUSE
    task automatic between();
`ifdef SEQ_SINGLE_STEP_EN
        if (!first_fetch) begin
            @(negedge clk);
            check("pause", actual(), mk(exp_pc, E_NONE));
            step = 1'b1;
        end
`endif
        first_fetch = 1'b0;
    endtask

    task automatic run_instr(input logic [15:0] iv, input logic b, input string tag);
        between();
        push_instr(iv, b);
        drain(exp_q.size(), iv, b, tag);
    endtask

    // Assert reset now, check the asynchronous clear, then restart from IDLE
    task automatic do_reset();
        reset = 1'b1;
        run   = 1'b0;
        #1;
        check("reset_async", actual(), mk('0, E_NONE));
        exp_q.delete();
        exp_pc = '0;
        @(negedge clk);
        check("reset_hold", actual(), mk('0, E_NONE));
        reset = 1'b0;
        @(negedge clk);
        check("idle_hold", actual(), mk('0, E_NONE));
        run         = 1'b1;
        first_fetch = 1'b1;
    endtask

    initial begin
        reset       = 1'b1;
        run         = 1'b0;
        ir          = '0;
        bool_alu    = 1'b0;
        step        = 1'b0;
        exp_pc      = '0;
        first_fetch = 1'b1;
        repeat (2) @(negedge clk);
        do_reset();

        // ALU ops walk pc from 0 to 10 with run held high
        for (int i = 0; i < 10; i++) run_instr(16'h0123, 1'($urandom_range(0, 1)), "alu_seq");
        run_instr(16'hD02A, 1'b1, "br_taken");
        run_instr(16'hC00A, 1'b1, "jmp_10");
        run_instr(16'hD02A, 1'b0, "br_not_taken");
        run_instr(16'hC03F, 1'b0, "jmp_63");
        run_instr(16'h0123, 1'b1, "alu_wrap");
        run_instr(16'h4005, 1'b0, "load");
        run_instr(16'h8005, 1'b1, "store");
        run_instr(16'hF000, 1'b1, "nop");
        run_instr(16'h7FC0, 1'b1, "load2");
        run_instr(16'hBFFF, 1'b0, "store2");
        run_instr(16'h3ABC, 1'b0, "alu2");
        run_instr(16'hE000, 1'b1, "halt");

        // HALT is sticky and ignores run
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("halt_hold", actual(), mk(exp_pc, E_HALT));
            run = 1'(i % 2);
        end
        do_reset();
        run_instr(16'h0123, 1'b0, "alu_after_halt");

        // Reset landing in MEM of a store clears dm_write_en before any edge
        between();
        push_instr(16'h8005, 1'b0);
        drain(4, 16'h8005, 1'b0, "store_pre_reset");
        #2;
        do_reset();
        run_instr(16'h4005, 1'b1, "load_after_reset");

`ifdef SEQ_SINGLE_STEP_EN
        // Without step the sequencer parks in PAUSE
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("pause_park", actual(), mk(exp_pc, E_NONE));
        end
        // Three pulses, three instructions, then parked again
        for (int i = 0; i < 3; i++) run_instr(16'h0123, 1'b0, "stepped_alu");
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("pause_after_steps", actual(), mk(exp_pc, E_NONE));
        end
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, %0d checks made", n_tests);
        $fatal(1, "watchdog expired");
    end

endmodule
